cmd_tx_sched: RTL and testbench

CMD_TX_SCHED -- requirements
Module: cmd_tx_sched

---
 rtl/cmd_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_cmd_tx_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_tx_sched.sv
// cmd_tx_sched
// Schedules the response to one upstream MREQ at a time. The module latches
// the request, hands it to the header generator and forwards the header bytes.
// For reads it then slices each 32-bit read-data word into byte lanes. At the
// end it acknowledges the request with a one-cycle o_mreq_ready pulse. The
// header and payload of one response are never interleaved with another
// response.
//
// MREQ field layout (as packed by mreq_defines.vh):
//   [0]      wr    : 1 = write (header only), 0 = read
//   [3:1]    wfmt  : 0=32S0 1=16S0 2=16S1 3=8S0 4=8S1 5=8S2 6=8S3, 7 undefined
//   [11:4]   wcnt  : number of payload words minus one
//   [N-1:12] opaque request bits, passed to the header generator
//
// Ports:
//   i_clk, i_rst_n                          clock, synchronous active-low reset
//   i_mreq_valid / o_mreq_ready / i_mreq    upstream request (ready = done pulse)
//   o_hdr_mreq_valid / i_hdr_mreq_ready /
//   o_hdr_mreq                              latched request to header generator
//   i_hdr_data / i_hdr_valid / o_hdr_ready  header byte stream
//   i_rdata / i_rdata_valid / o_rdata_ready read-data word stream
//   o_tx_data / o_tx_valid / i_tx_ready     merged output byte stream
//
// Build option: CMD_TX_SCHED_OREG_EN. When it is defined, the output stream
// comes from a 2-entry skid register. This adds one cycle of latency and
// breaks the i_tx_ready to o_hdr_ready/o_rdata_ready path.
//
// state | meaning
// IDLE  | waiting for i_mreq_valid, request latched on acceptance
// HDR   | request offered to header generator, header bytes forwarded
// DATA  | payload bytes sliced from read-data words
// DONE  | output drained, o_mreq_ready pulsed for one cycle
module cmd_tx_sched #(
  parameter int MREQ_NBIT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_mreq_valid,
  output logic                 o_mreq_ready,
  input  logic [MREQ_NBIT-1:0] i_mreq,
  output logic                 o_hdr_mreq_valid,
  input  logic                 i_hdr_mreq_ready,
  output logic [MREQ_NBIT-1:0] o_hdr_mreq,
  input  logic [7:0]           i_hdr_data,
  input  logic                 i_hdr_valid,
  output logic                 o_hdr_ready,
  input  logic [31:0]          i_rdata,
  input  logic                 i_rdata_valid,
  output logic                 o_rdata_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [2:0] wfmt;
    logic [7:0] wcnt;
  } mreq_f_t;

  function automatic mreq_f_t unpack_mreq(input logic [11:0] v);
    mreq_f_t f;
    f.wr   = v[0];
    f.wfmt = v[3:1];
    f.wcnt = v[11:4];
    return f;
  endfunction

  function automatic logic fmt_is_read(input logic [2:0] fmt);
    return (fmt != 3'd7);
  endfunction

  // Index of the last byte lane in a word: 3 for 32S0, 1 for 16Sk, 0 for 8Sk.
  function automatic logic [1:0] fmt_last_lane(input logic [2:0] fmt);
    logic [1:0] l;
    case (fmt)
      3'd0:       l = 2'd3;
      3'd1, 3'd2: l = 2'd1;
      default:    l = 2'd0;
    endcase
    return l;
  endfunction

  // Byte offset of the first lane inside the 32-bit word.
  function automatic logic [1:0] fmt_base_byte(input logic [2:0] fmt);
    logic [1:0] b;
    case (fmt)
      3'd2:    b = 2'd2;
      3'd4:    b = 2'd1;
      3'd5:    b = 2'd2;
      3'd6:    b = 2'd3;
      default: b = 2'd0;
    endcase
    return b;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MREQ_NBIT-1:0]   r_mreq;
  logic                   r_wr;
  logic [2:0]             r_wfmt;
  logic [7:0]             r_wcnt;
  logic [7:0]             r_word_cnt;
  logic [1:0]             r_lane;

  mreq_f_t                w_fields;
  logic                   w_lane_last;
  logic [1:0]             w_byte_idx;
  logic [7:0]             w_lane_byte;
  logic                   w_int_valid;
  logic [7:0]             w_int_data;
  logic                   w_int_ready;
  logic                   w_int_hs;
  logic                   w_skid_empty;

  assign w_fields    = unpack_mreq(i_mreq[11:0]);
  assign w_lane_last = (r_lane == fmt_last_lane(r_wfmt));
  assign w_byte_idx  = fmt_base_byte(r_wfmt) + r_lane;
  assign w_int_hs    = w_int_valid & w_int_ready;

  always_comb begin
    w_lane_byte = i_rdata[7:0];
    case (w_byte_idx)
      2'd1:    w_lane_byte = i_rdata[15:8];
      2'd2:    w_lane_byte = i_rdata[23:16];
      2'd3:    w_lane_byte = i_rdata[31:24];
      default: w_lane_byte = i_rdata[7:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_hdr_mreq_valid = 1'b0;
    o_hdr_mreq       = '0;
    o_hdr_ready      = 1'b0;
    o_rdata_ready    = 1'b0;
    o_mreq_ready     = 1'b0;
    w_int_valid      = 1'b0;
    w_int_data       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_mreq_valid) begin
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        o_hdr_mreq_valid = 1'b1;
        o_hdr_mreq       = r_mreq;
        w_int_valid      = i_hdr_valid;
        w_int_data       = i_hdr_data;
        o_hdr_ready      = w_int_ready;
        if (i_hdr_mreq_ready) begin
          if (r_wr || !fmt_is_read(r_wfmt)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_int_valid = i_rdata_valid;
        w_int_data  = w_lane_byte;
        // The word is released only when its last lane leaves, so i_rdata
        // stays put while the earlier lanes are sent.
        o_rdata_ready = w_int_hs & w_lane_last;
        if (w_int_hs && w_lane_last && (r_word_cnt == 8'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_skid_empty) begin
          o_mreq_ready = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mreq     <= '0;
      r_wr       <= 1'b0;
      r_wfmt     <= 3'd0;
      r_wcnt     <= 8'd0;
      r_word_cnt <= 8'd0;
      r_lane     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mreq_valid) begin
            r_mreq <= i_mreq;
            r_wr   <= w_fields.wr;
            r_wfmt <= w_fields.wfmt;
            r_wcnt <= w_fields.wcnt;
          end
        end
        S_HDR: begin
          if (i_hdr_mreq_ready) begin
            r_word_cnt <= r_wcnt;
            r_lane     <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_int_hs) begin
            if (w_lane_last) begin
              r_lane <= 2'd0;
              // Counting down to zero keeps wcnt=255 inside 8 bits.
              if (r_word_cnt != 8'd0) begin
                r_word_cnt <= r_word_cnt - 8'd1;
              end
            end else begin
              r_lane <= r_lane + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMD_TX_SCHED_OREG_EN
  logic [7:0] r_skid_q0;
  logic [7:0] r_skid_q1;
  logic [1:0] r_skid_cnt;
  logic       w_push;
  logic       w_pop;

  // The ready signal depends only on the registered fill level.
  assign w_int_ready  = (r_skid_cnt != 2'd2);
  assign w_skid_empty = (r_skid_cnt == 2'd0);
  assign o_tx_valid   = !w_skid_empty;
  assign o_tx_data    = w_skid_empty ? 8'h00 : r_skid_q0;
  assign w_push       = w_int_hs;
  assign w_pop        = o_tx_valid & i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_skid_q0  <= 8'h00;
      r_skid_q1  <= 8'h00;
      r_skid_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) begin
            r_skid_q0 <= w_int_data;
          end else begin
            r_skid_q1 <= w_int_data;
          end
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid_q0  <= r_skid_q1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          // A push is only possible below two entries. With one entry, the
          // new byte replaces the one leaving.
          r_skid_q0 <= w_int_data;
        end
        default: ;
      endcase
    end
  end
`else
  assign w_int_ready  = i_tx_ready;
  assign w_skid_empty = 1'b1;
  assign o_tx_valid   = w_int_valid;
  assign o_tx_data    = w_int_data;
`endif

endmodule

// File: tb/tb_cmd_tx_sched.sv
module tb_cmd_tx_sched;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_mreq_valid;
  logic        o_mreq_ready;
  logic [31:0] i_mreq;
  logic        o_hdr_mreq_valid;
  logic        i_hdr_mreq_ready;
  logic [31:0] o_hdr_mreq;
  logic [7:0]  i_hdr_data;
  logic        i_hdr_valid;
  logic        o_hdr_ready;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;
  logic        o_rdata_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  cmd_tx_sched #(.MREQ_NBIT(32)) u_dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_mreq_valid     (i_mreq_valid),
    .o_mreq_ready     (o_mreq_ready),
    .i_mreq           (i_mreq),
    .o_hdr_mreq_valid (o_hdr_mreq_valid),
    .i_hdr_mreq_ready (i_hdr_mreq_ready),
    .o_hdr_mreq       (o_hdr_mreq),
    .i_hdr_data       (i_hdr_data),
    .i_hdr_valid      (i_hdr_valid),
    .o_hdr_ready      (o_hdr_ready),
    .i_rdata          (i_rdata),
    .i_rdata_valid    (i_rdata_valid),
    .o_rdata_ready    (o_rdata_ready),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

`ifdef CMD_TX_SCHED_OREG_EN
  localparam int FIRST_LAT = 4;
`else
  localparam int FIRST_LAT = 3;
`endif
  localparam int HDR_LEN = 5;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] rd_words[$];
  logic [7:0]  hdr_bytes[HDR_LEN];
  int          exp_words;
  int          hdr_sent, rd_idx, pulses, rd_hs_cnt, rd_ready_cnt, cyc, first_cyc;
  bit          hdr_seen, hdr_done, rnd_en, scramble;
  int          ready_mode;
  logic        prev_valid, prev_ready;
  logic [7:0]  prev_data;
  logic [31:0] cur_vec;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit wr, input int fmt, input int wcnt,
                                     input logic [19:0] hi);
    return {hi, 8'(wcnt), 3'(fmt), wr};
  endfunction

  // Expected output: the header bytes, then every word's lanes in order.
  task automatic build_exp(input logic [31:0] vec);
    int  fmt, wcnt, bpw, base;
    bit  wr;
    wr   = vec[0];
    fmt  = int'(vec[3:1]);
    wcnt = int'(vec[11:4]);
    exp_q.delete();
    for (int i = 0; i < HDR_LEN; i++) begin
      hdr_bytes[i] = 8'($urandom);
      exp_q.push_back(hdr_bytes[i]);
    end
    exp_words = 0;
    if (!wr && fmt <= 6) begin
      bpw  = (fmt == 0) ? 4 : (fmt <= 2) ? 2 : 1;
      base = (fmt == 0) ? 0 : (fmt <= 2) ? 2 * (fmt - 1) : fmt - 3;
      exp_words = wcnt + 1;
      for (int w = 0; w <= wcnt; w++)
        for (int b = 0; b < bpw; b++)
          exp_q.push_back(8'(rd_words[w] >> (8 * (base + b))));
    end
  endtask

  task automatic step();
    logic tx_hs, hdr_hs, hm_hs, rd_hs, ack;
    @(negedge i_clk);
    cyc++;
    if (prev_valid && !prev_ready)
      chk("stall_hold", {55'd0, o_tx_valid, o_tx_data}, {55'd0, 1'b1, prev_data});
    prev_valid = o_tx_valid;
    prev_ready = i_tx_ready;
    prev_data  = o_tx_data;
    tx_hs  = o_tx_valid & i_tx_ready;
    hdr_hs = i_hdr_valid & o_hdr_ready;
    hm_hs  = o_hdr_mreq_valid & i_hdr_mreq_ready;
    rd_hs  = i_rdata_valid & o_rdata_ready;
    ack    = o_mreq_ready;
    if (tx_hs) begin
      got_q.push_back(o_tx_data);
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (o_hdr_mreq_valid && !hdr_seen) begin
      hdr_seen = 1'b1;
      chk("hdr_mreq", {32'd0, o_hdr_mreq}, {32'd0, cur_vec});
    end
    if (o_rdata_ready) rd_ready_cnt++;
    if (rd_hs) rd_hs_cnt++;
    if (ack) pulses++;
    @(posedge i_clk);
    #1;
    if (hdr_hs) hdr_sent++;
    if (hm_hs) hdr_done = 1'b1;
    if (rd_hs) rd_idx++;
    i_hdr_mreq_ready = 1'b0;
    if (hdr_seen && !hdr_done) begin
      if (hdr_sent < HDR_LEN) begin
        if (!(i_hdr_valid && !hdr_hs)) begin
          i_hdr_valid = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          i_hdr_data  = hdr_bytes[hdr_sent];
        end
      end else begin
        i_hdr_valid      = 1'b0;
        i_hdr_mreq_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end else begin
      i_hdr_valid = 1'b0;
    end
    if (!(i_rdata_valid && !rd_hs)) begin
      if (rd_idx < rd_words.size()) begin
        i_rdata_valid = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_rdata       = rd_words[rd_idx];
      end else begin
        i_rdata_valid = 1'b0;
        i_rdata       = $urandom;
      end
    end
    case (ready_mode)
      1:       i_tx_ready = 1'($urandom_range(0, 1));
      2:       i_tx_ready = ~i_tx_ready;
      default: i_tx_ready = 1'b1;
    endcase
    if (ack) i_mreq_valid = 1'b0;
    else if (scramble) i_mreq = $urandom;
  endtask

  // Runs one request to completion (abort_n < 0) or until abort_n payload
  // bytes have left the DUT.
  task automatic run_req(input logic [31:0] vec, input int abort_n, input int budget);
    build_exp(vec);
    got_q.delete();
    hdr_sent = 0; rd_idx = 0; pulses = 0; rd_hs_cnt = 0; rd_ready_cnt = 0;
    cyc = 0; first_cyc = -1; hdr_seen = 1'b0; hdr_done = 1'b0;
    prev_valid = 1'b0;
    cur_vec = vec;
    i_hdr_valid = 1'b0; i_rdata_valid = 1'b0;
    i_tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    i_mreq = vec;
    i_mreq_valid = 1'b1;
    while (pulses == 0 && cyc < budget) begin
      step();
      if (abort_n >= 0 && got_q.size() == HDR_LEN + abort_n) break;
    end
    if (abort_n < 0) begin
      step();
      step();
      chk("ack_pulses", 64'(pulses), 64'd1);
      chk("byte_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("byte%0d", i), {56'd0, got_q[i]}, {56'd0, exp_q[i]});
      chk("rdata_hs", 64'(rd_hs_cnt), 64'(exp_words));
      if (exp_words == 0) chk("rdata_ready_idle", 64'(rd_ready_cnt), 64'd0);
    end
  endtask

  task automatic set_words(input int n);
    rd_words.delete();
    for (int i = 0; i < n; i++) rd_words.push_back($urandom);
  endtask

  logic [7:0] k028[8];
  int         quiet;

  initial begin
    k028 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    i_rst_n = 1'b0; i_mreq_valid = 1'b0; i_mreq = '0; i_hdr_mreq_ready = 1'b0;
    i_hdr_data = '0; i_hdr_valid = 1'b0; i_rdata = '0; i_rdata_valid = 1'b0;
    i_tx_ready = 1'b0;
    rnd_en = 1'b0; scramble = 1'b0; ready_mode = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outs", {19'd0, o_mreq_ready, o_hdr_mreq_valid, o_hdr_mreq, o_hdr_ready,
                       o_rdata_ready, o_tx_data, o_tx_valid}, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Write: header only, words on offer must never be consumed.
    set_words(4);
    run_req(mk(1'b1, 0, 3, 20'h12345), -1, 200);

    // Read 32S0 with fixed words, no stalls: checks latency too.
    rd_words = '{32'h44332211, 32'h88776655};
    run_req(mk(1'b0, 0, 1, 20'h0), -1, 200);
    chk("first_byte_lat", 64'(first_cyc), 64'(FIRST_LAT));
    for (int i = 0; i < 8; i++)
      chk($sformatf("r028_p%0d", i), {56'd0, got_q[HDR_LEN + i]}, {56'd0, k028[i]});

    rd_words = '{32'hAABBCCDD};
    run_req(mk(1'b0, 2, 0, 20'h0), -1, 200);
    chk("r029_16s1_b0", {56'd0, got_q[HDR_LEN]}, 64'hBB);
    chk("r029_16s1_b1", {56'd0, got_q[HDR_LEN + 1]}, 64'hAA);
    run_req(mk(1'b0, 5, 0, 20'h0), -1, 200);
    chk("r029_8s2_b0", {56'd0, got_q[HDR_LEN]}, 64'hBB);

    // 256 single-byte words with ready toggling every cycle.
    ready_mode = 2;
    set_words(256);
    run_req(mk(1'b0, 3, 255, 20'hABCDE), -1, 2000);
    chk("r030_payload_len", 64'(got_q.size() - HDR_LEN), 64'd256);

    // Undefined read format: header only.
    ready_mode = 0;
    set_words(2);
    run_req(mk(1'b0, 7, 1, 20'h0), -1, 200);

    // Randomized traffic with gaps, backpressure and upstream churn.
    rnd_en = 1'b1; scramble = 1'b1;
    for (int t = 0; t < 20; t++) begin
      int wc;
      wc = $urandom_range(0, 12);
      ready_mode = $urandom_range(0, 2);
      set_words(wc + 1);
      run_req(mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), wc, 20'($urandom)),
              -1, 200 + 16 * (wc + 1));
    end

    // Reset after the third payload byte of a 32S0 response.
    rnd_en = 1'b0; scramble = 1'b0; ready_mode = 0;
    set_words(4);
    run_req(mk(1'b0, 0, 3, 20'h55555), 3, 300);
    chk("abort_bytes", 64'(got_q.size()), 64'(HDR_LEN + 3));
    chk("abort_no_ack", 64'(pulses), 64'd0);
    i_rst_n = 1'b0; i_tx_ready = 1'b0; i_mreq_valid = 1'b0; i_hdr_valid = 1'b0;
    i_hdr_mreq_ready = 1'b0; i_rdata_valid = 1'b0;
    prev_valid = 1'b0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("abort_outs", {19'd0, o_mreq_ready, o_hdr_mreq_valid, o_hdr_mreq, o_hdr_ready,
                       o_rdata_ready, o_tx_data, o_tx_valid}, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_tx_ready = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_mreq_ready || o_tx_valid) quiet++;
    end
    chk("abort_quiet", 64'(quiet), 64'd0);
    @(posedge i_clk);
    #1;

    set_words(3);
    run_req(mk(1'b0, 0, 2, 20'h0F0F0), -1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
